// File: rtl/sprite_pkg.sv
// sprite_pkg: shared glyph geometry, bitmap types and serializer states
package sprite_pkg;
  localparam int GLYPH_ROWS = 16;
  localparam int GLYPH_COLS = 8;
  typedef logic [7:0] glyph_row_t;
  typedef glyph_row_t [0:15] glyph_t;
  typedef enum logic [1:0] {IDLE, FETCH, STREAM} ser_state_e;
endpackage

// File: rtl/sprite_glyph_serializer.sv
// sprite_glyph_serializer: fetches a glyph bitmap from the ROM and streams it pixel by pixel in raster order
module sprite_glyph_serializer
  import sprite_pkg::*;
#(
  parameter int ROWS = GLYPH_ROWS,
  parameter int COLS = GLYPH_COLS,
  parameter bit LEFT_IS_MSB = 1'b1
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          char_valid,
  input  logic [7:0]                    char_code,
  output logic                          char_ready,
  output logic [7:0]                    sprite_index,
  input  logic [0:ROWS-1][COLS-1:0]     sprite,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic                          pix_on,
  output logic [$clog2(COLS)-1:0]       pix_x,
  output logic [$clog2(ROWS)-1:0]       pix_y,
  output logic                          pix_last,
  output logic                          busy
);
  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam logic [XW-1:0] XMAX = XW'(COLS - 1);
  localparam logic [YW-1:0] YMAX = YW'(ROWS - 1);
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_FETCH = FETCH;
  localparam logic [1:0] ST_STREAM = STREAM;
  logic [1:0] state;
  logic [0:ROWS-1][COLS-1:0] glyph;
  logic [COLS-1:0] row;
  logic [XW-1:0] col;
  logic fire;
  assign char_ready = state == ST_IDLE;
  assign busy = state != ST_IDLE;
  assign pix_valid = state == ST_STREAM;
  assign fire = pix_valid & pix_ready;
  assign row = glyph[pix_y];
  assign col = LEFT_IS_MSB ? XMAX - pix_x : pix_x;
  assign pix_on = pix_valid & row[col];
  assign pix_last = pix_valid && pix_x == XMAX && pix_y == YMAX;
  // the ROM is combinational from sprite_index, so FETCH gives it one full cycle before capture
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= ST_IDLE;
      sprite_index <= '0;
      glyph <= '0;
      pix_x <= '0;
      pix_y <= '0;
    end else begin
      case (state)
        ST_IDLE: if (char_valid) begin
          sprite_index <= char_code;
          state <= ST_FETCH;
        end
        ST_FETCH: begin
          glyph <= sprite;
          pix_x <= '0;
          pix_y <= '0;
          state <= ST_STREAM;
        end
        ST_STREAM: if (fire) begin
          if (pix_last) begin
            pix_x <= '0;
            pix_y <= '0;
            state <= ST_IDLE;
          end else if (pix_x == XMAX) begin
            pix_x <= '0;
            pix_y <= pix_y + 1'b1;
          end else begin
            pix_x <= pix_x + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sprite_glyph_serializer.sv
// tb_sprite_glyph_serializer: randomized raster-order checks of the glyph serializer against a pixel-list model
module tb_sprite_glyph_serializer;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic char_valid = 1'b0;
  logic [7:0] char_code = 8'h00;
  logic char_ready;
  logic [7:0] sprite_index;
  logic [0:15][7:0] sprite;
  logic pix_valid;
  logic pix_ready = 1'b0;
  logic pix_on;
  logic [2:0] pix_x;
  logic [3:0] pix_y;
  logic pix_last;
  logic busy;
  logic scramble = 1'b0;
  logic [7:0] rom [256][16];
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  sprite_glyph_serializer dut (
    .Clk(Clk), .Reset_n(Reset_n), .char_valid(char_valid), .char_code(char_code),
    .char_ready(char_ready), .sprite_index(sprite_index), .sprite(sprite),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_on(pix_on), .pix_x(pix_x),
    .pix_y(pix_y), .pix_last(pix_last), .busy(busy)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // behavioural glyph ROM; scramble corrupts it after capture to prove it is sampled only once
  always_comb begin
    for (int r = 0; r < 16; r++) sprite[r] = rom[sprite_index][r] ^ {8{scramble}};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic exp_on(input logic [7:0] code, input int idx);
    logic [7:0] r;
    r = rom[code][idx / 8];
    return r[7 - (idx % 8)];
  endfunction

  task automatic send(input logic [7:0] code, output int acc);
    int g = 0;
    while (!char_ready && g < 1000) begin
      @(posedge Clk); #1; g++;
    end
    check("send_ready", {31'd0, char_ready}, 1);
    char_valid = 1'b1;
    char_code = code;
    acc = cyc;
    @(posedge Clk); #1;
    char_valid = 1'b0;
    check("fetch_valid", {31'd0, pix_valid}, 0);
    check("fetch_ready", {31'd0, char_ready}, 0);
    check("fetch_busy", {31'd0, busy}, 1);
    check("index", {24'd0, sprite_index}, {24'd0, code});
    @(posedge Clk); #1;
    check("first_valid", {31'd0, pix_valid}, 1);
    check("first_xy", {25'd0, pix_y, pix_x}, 0);
  endtask

  task automatic stream(input logic [7:0] code, input bit bp, input int inject, input int abort_at);
    int idx = 0;
    int g = 0;
    bit injected = 1'b0;
    scramble = 1'b1;
    while (idx < 128 && g < 2000 && idx != abort_at) begin
      check("valid", {31'd0, pix_valid}, 1);
      check("char_ready_low", {31'd0, char_ready}, 0);
      check("x", {29'd0, pix_x}, idx % 8);
      check("y", {28'd0, pix_y}, idx / 8);
      check("on", {31'd0, pix_on}, {31'd0, exp_on(code, idx)});
      check("last", {31'd0, pix_last}, {31'd0, idx == 127});
      char_valid = (idx == inject) && !injected;
      char_code = 8'h62;
      if (char_valid) injected = 1'b1;
      pix_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pix_ready) idx++;
      @(posedge Clk); #1;
      g++;
    end
    pix_ready = 1'b0;
    char_valid = 1'b0;
    scramble = 1'b0;
    if (idx != abort_at) begin
      check("beats", idx, 128);
      check("index_held", {24'd0, sprite_index}, {24'd0, code});
      check("done_ready", {31'd0, char_ready}, 1);
      check("done_busy", {31'd0, busy}, 0);
      check("done_valid", {31'd0, pix_valid}, 0);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, {31'd0, pix_valid}, 0);
    check({tag, "_ready"}, {31'd0, char_ready}, 1);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_xy"}, {25'd0, pix_y, pix_x}, 0);
    check({tag, "_last"}, {31'd0, pix_last}, 0);
    check({tag, "_on"}, {31'd0, pix_on}, 0);
  endtask

  initial begin
    int acc;
    logic [7:0] c;
    for (int i = 0; i < 256; i++)
      for (int r = 0; r < 16; r++) rom[i][r] = 8'($urandom);
    for (int r = 0; r < 16; r++) begin
      rom[8'h7A][r] = 8'h00;
      rom[8'h61][r] = 8'h00;
    end
    rom[8'h61][4] = 8'b01111000;
    rom[8'h61][5] = 8'b00001100;
    rom[8'h61][6] = 8'b01111100;
    rom[8'h61][7] = 8'b11001100;
    rom[8'h61][8] = 8'b11001100;
    rom[8'h61][9] = 8'b11001100;
    rom[8'h61][10] = 8'b01110110;
    repeat (3) @(posedge Clk);
    #1;
    check_idle("reset");
    check("reset_index", {24'd0, sprite_index}, 0);
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    check_idle("post_reset");
    // continuous 'a' with latency measurement
    send(8'h61, acc);
    stream(8'h61, 1'b0, -1, -1);
    check("ready_latency", cyc - acc, 130);
    // backpressure plus a rejected code during STREAM
    send(8'h61, acc);
    stream(8'h61, 1'b1, 20, -1);
    // zero glyph then back-to-back accept on the first IDLE cycle
    send(8'h7A, acc);
    stream(8'h7A, 1'b1, -1, -1);
    send(8'h61, acc);
    stream(8'h61, 1'b0, -1, -1);
    for (int k = 0; k < 5; k++) begin
      c = 8'($urandom);
      send(c, acc);
      stream(c, 1'b1, $urandom_range(0, 127), -1);
    end
    // abort mid-glyph at row 5
    send(8'h61, acc);
    stream(8'h61, 1'b0, -1, 40);
    check("abort_y", {28'd0, pix_y}, 5);
    Reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      check("rst_no_last", {31'd0, pix_last}, 0);
      check("rst_no_valid", {31'd0, pix_valid}, 0);
    end
    Reset_n = 1'b1;
    check_idle("abort");
    check("abort_index", {24'd0, sprite_index}, 0);
    @(posedge Clk); #1;
    check_idle("abort_idle");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
